// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: reads an instruction from imem, offers it to the execute
// stage, then adopts exec_pc as the next fetch address. FETCH_PERF_EN adds perf counters.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       INST_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [INST_W-1:0] imem_data,
  input  logic              imem_valid,
  output logic              exec_en,
  output logic [INST_W-1:0] exec_inst,
  input  logic              exec_ready,
  input  logic [ADDR_W-1:0] exec_pc,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       retired,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_FAULT
  } state_t;

  localparam int unsigned       CNT_W    = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc_next;
  logic [INST_W-1:0]   inst_next;
  logic [CNT_W-1:0]    wait_cnt, cnt_next;
  logic                halt_pend, pend_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      exec_inst <= '0;
      wait_cnt  <= '0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= pc_next;
      exec_inst <= inst_next;
      wait_cnt  <= cnt_next;
      halt_pend <= pend_next;
    end
  end

  assign imem_addr = fetch_pc;

  // A halt request seen at any point of a busy instruction is remembered so that a
  // short pulse still stops the sequencer at the following instruction boundary.
  always_comb begin
    state_next = state;
    pc_next    = fetch_pc;
    inst_next  = exec_inst;
    cnt_next   = wait_cnt;
    pend_next  = halt_pend;
    imem_rd    = 1'b0;
    exec_en    = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_next = S_FETCH;
          pc_next    = RESET_PC;
        end
      end
      S_FETCH: begin
        imem_rd = 1'b1;
        busy    = 1'b1;
        if (halt_req) pend_next = 1'b1;
        if (imem_valid) begin
          inst_next  = imem_data;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        exec_en    = 1'b1;
        busy       = 1'b1;
        cnt_next   = '0;
        if (halt_req) pend_next = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        exec_en = 1'b1;
        busy    = 1'b1;
        if (exec_ready) begin
          pc_next  = exec_pc;
          cnt_next = '0;
          if (halt_req || halt_pend || !run) begin
            state_next = S_HALT;
            pend_next  = 1'b0;
          end else begin
            state_next = S_FETCH;
          end
        end else begin
          if (halt_req) pend_next = 1'b1;
          if (wait_cnt == CNT_LAST) begin
            state_next = S_FAULT;
          end else begin
            cnt_next = wait_cnt + 1'b1;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (run && !halt_req) state_next = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == S_WAIT && exec_ready && retired != '1) begin
        retired <= retired + 16'd1;
      end
      if (state == S_FETCH && !imem_valid && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: responders model imem and the execute stage,
// a planned instruction trace supplies the expected (pc, inst) issue order.
module tb_fetch_sequencer;

  localparam logic [7:0] RST_PC = 8'h40;
  localparam int         TMO    = 8;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] inst;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, run, halt_req, auto_halt, man_halt;
  logic [7:0] imem_addr, imem_data, exec_inst, exec_pc, fetch_pc;
  logic       imem_rd, imem_valid, exec_en, exec_ready, busy, halted, fault;
`ifdef FETCH_PERF_EN
  logic [15:0] retired, stall_cycles;
  logic [15:0] s0, r0;
`endif

  assign halt_req = auto_halt | man_halt;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W(8),
    .INST_W(8),
    .RESET_PC(RST_PC),
    .WAIT_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .halt_req(halt_req),
    .imem_addr(imem_addr),
    .imem_rd(imem_rd),
    .imem_data(imem_data),
    .imem_valid(imem_valid),
    .exec_en(exec_en),
    .exec_inst(exec_inst),
    .exec_ready(exec_ready),
    .exec_pc(exec_pc),
    .fetch_pc(fetch_pc),
    .busy(busy),
    .halted(halted),
    .fault(fault)
`ifdef FETCH_PERF_EN
    ,
    .retired(retired),
    .stall_cycles(stall_cycles)
`endif
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem [256];
  exp_t       exp_q [$];
  logic [7:0] next_q [$];
  int         rise_q [$];
  logic [7:0] model_pc;
  int         mem_lat_fixed, exec_lat_fixed;
  bit         held_mode, ready_never, use_auto_halt, stop_by_run;
  int         cyc = 0;
  int         m_rd_n, m_cur, e_cnt, e_lat;
  bit         e_stale;
  int         en_len, last_en_len, rd_len, last_rd_len;
  logic       prev_en, prev_rd;
  logic [7:0] held_inst, rd_addr;
  exp_t       e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic plan(input logic [7:0] pc, input logic [7:0] nxt);
    exp_t x;
    x.pc   = pc;
    x.inst = mem[pc];
    exp_q.push_back(x);
    next_q.push_back(nxt);
    model_pc = nxt;
  endtask

  task automatic plan_random(input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned r;
      logic [7:0]  nxt;
      r = $urandom_range(0, 3);
      if (r == 0)      nxt = model_pc;
      else if (r == 1) nxt = 8'(model_pc + 8'd1);
      else             nxt = 8'($urandom);
      plan(model_pc, nxt);
    end
  endtask

  task automatic resume();
    @(negedge clk);
    auto_halt = 1'b0;
    run       = 1'b1;
  endtask

  task automatic wait_halted(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_exp_drained"}, exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: latency counted in FETCH cycles, garbage data while not valid.
  initial begin
    imem_valid = 1'b0;
    imem_data  = '0;
    m_rd_n     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !imem_rd) begin
        imem_valid = 1'b0;
        m_rd_n     = 0;
      end else begin
        if (m_rd_n == 0) m_cur = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 3));
        if (m_rd_n >= m_cur) begin
          imem_valid = 1'b1;
          imem_data  = mem[imem_addr];
        end else begin
          imem_valid = 1'b0;
          imem_data  = 8'($urandom);
        end
        m_rd_n++;
      end
    end
  end

  // Execute stage: optional stale ready during the offer cycle, then ready after a delay.
  initial begin
    exec_ready = 1'b0;
    exec_pc    = '0;
    e_cnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        exec_ready = 1'b0;
        e_cnt      = 0;
      end else if (exec_en) begin
        if (e_cnt == 0) begin
          e_lat   = held_mode ? 0 : ((exec_lat_fixed >= 0) ? exec_lat_fixed : int'($urandom_range(0, 4)));
          e_stale = !held_mode && ($urandom_range(0, 1) == 1);
        end
        if (ready_never) begin
          exec_ready = 1'b0;
        end else if (e_cnt == 0) begin
          exec_ready = held_mode || e_stale;
          exec_pc    = (held_mode && next_q.size() > 0) ? next_q[0] : 8'($urandom);
        end else if (e_cnt >= 1 + e_lat) begin
          exec_ready = 1'b1;
          exec_pc    = (next_q.size() > 0) ? next_q[0] : 8'($urandom);
          if (next_q.size() == 1 && use_auto_halt) begin
            if (stop_by_run) run = 1'b0;
            else             auto_halt = 1'b1;
          end
        end else begin
          exec_ready = 1'b0;
          exec_pc    = 8'($urandom);
        end
        e_cnt++;
      end else begin
        if (e_cnt > 0 && exec_ready && next_q.size() > 0) void'(next_q.pop_front());
        e_cnt      = 0;
        exec_ready = 1'b0;
      end
    end
  end

  // Monitor: every new offer is popped from the scoreboard and compared.
  initial begin
    prev_en = 1'b0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0;
        prev_rd = 1'b0;
      end else begin
        if (exec_en && !prev_en) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_unexpected: got issue at pc 0x%0h, expected none", fetch_pc);
          end else begin
            e = exp_q.pop_front();
            check("issue_pc", 32'(fetch_pc), 32'(e.pc));
            check("issue_inst", 32'(exec_inst), 32'(e.inst));
          end
          held_inst = exec_inst;
          en_len    = 1;
          rise_q.push_back(cyc);
        end else if (exec_en) begin
          check("inst_stable", 32'(exec_inst), 32'(held_inst));
          en_len++;
        end else if (prev_en) begin
          last_en_len = en_len;
        end
        if (imem_rd) begin
          if (!prev_rd) begin
            rd_addr = imem_addr;
            rd_len  = 0;
          end else begin
            check("rd_addr_stable", 32'(imem_addr), 32'(rd_addr));
          end
          check("no_en_in_fetch", 32'(exec_en), 32'd0);
          rd_len++;
        end else if (prev_rd) begin
          last_rd_len = rd_len;
        end
        prev_en = exec_en;
        prev_rd = imem_rd;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached without finishing");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0; run = 1'b0; auto_halt = 1'b0; man_halt = 1'b0;
    mem_lat_fixed = -1; exec_lat_fixed = -1;
    held_mode = 1'b0; ready_never = 1'b0; use_auto_halt = 1'b1; stop_by_run = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_imem_rd", 32'(imem_rd), 0);
    check("rst_exec_en", 32'(exec_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_fetch_pc", 32'(fetch_pc), 32'(RST_PC));
    check("rst_exec_inst", 32'(exec_inst), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_imem_rd", 32'(imem_rd), 0);
    model_pc = RST_PC;

    // Zero-latency walk including wrap and self-jump.
    mem[RST_PC] = 8'h3A;
    mem_lat_fixed = 0; exec_lat_fixed = 0;
    plan(RST_PC, 8'h05); plan(8'h05, 8'hFF); plan(8'hFF, 8'h00); plan(8'h00, 8'h00); plan(8'h00, 8'h10);
    rise_q.delete();
    resume();
    wait_halted(100, "walk");
    check("walk_fetch_pc", 32'(fetch_pc), 32'h10);
    check("walk_issues", rise_q.size(), 5);
    for (int i = 1; i < rise_q.size(); i++) check("walk_interval", rise_q[i] - rise_q[i-1], 3);

    // Halt pulse during FETCH of 0x10, then automatic resume at 0x11.
    mem_lat_fixed = 2; exec_lat_fixed = 1;
    plan(8'h10, 8'h11);
    plan_random(6);
    resume();
    for (int i = 0; i < 20; i++) begin
      if (imem_rd) break;
      @(negedge clk);
    end
    man_halt = 1'b1;
    @(negedge clk);
    man_halt = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    check("hpulse_halted", 32'(halted), 1);
    check("hpulse_fetch_pc", 32'(fetch_pc), 32'h11);
    mem_lat_fixed = -1; exec_lat_fixed = -1;
    @(negedge clk);
    check("hpulse_resume_busy", 32'(busy), 1);
    wait_halted(300, "after_halt");

    // Randomized segments ending by halt_req or by dropping run.
    for (int s = 0; s < 8; s++) begin
      held_mode   = ($urandom_range(0, 2) == 0);
      stop_by_run = ($urandom_range(0, 1) == 1);
      plan_random(int'($urandom_range(1, 8)));
      resume();
      wait_halted(400, "rand_seg");
      check("rand_fetch_pc", 32'(fetch_pc), 32'(model_pc));
    end
    held_mode = 1'b0; stop_by_run = 1'b0;

    // Memory latency of 4 extra cycles.
    mem_lat_fixed = 4; exec_lat_fixed = 0;
`ifdef FETCH_PERF_EN
    s0 = stall_cycles; r0 = retired;
`endif
    plan_random(1);
    resume();
    wait_halted(50, "slow_mem");
    check("slow_mem_rd_len", last_rd_len, 5);
`ifdef FETCH_PERF_EN
    check("perf_stall", 32'(stall_cycles - s0), 4);
    check("perf_retired", 32'(retired - r0), 1);
`endif
    mem_lat_fixed = -1;

    // Ready held high from the offer cycle: accepted on first WAIT cycle only.
    held_mode = 1'b1;
    plan_random(1);
    resume();
    wait_halted(50, "held_ready");
    check("held_ready_en_len", last_en_len, 2);
    held_mode = 1'b0;

    // Reset while waiting for ready.
    ready_never = 1'b1;
    plan_random(1);
    resume();
    for (int n = 0, i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (exec_en) n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_exec_en", 32'(exec_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_fetch_pc", 32'(fetch_pc), 32'(RST_PC));
    check("midrst_imem_rd", 32'(imem_rd), 0);
    run = 1'b0; auto_halt = 1'b0;
    exp_q.delete(); next_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = RST_PC;

    // Watchdog timeout into sticky FAULT.
    plan_random(1);
    resume();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fault) break;
    end
    @(negedge clk);
    check("tmo_fault", 32'(fault), 1);
    check("tmo_en_len", last_en_len, TMO + 1);
    check("tmo_exec_en", 32'(exec_en), 0);
    check("tmo_exp_drained", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run = ~run;
    end
    check("tmo_sticky", 32'(fault), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_imem_rd", 32'(imem_rd), 0);
    rst_n = 1'b0; run = 1'b0; ready_never = 1'b0;
    exp_q.delete(); next_q.delete();
    @(negedge clk);
    check("tmo_rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
